// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the FFT frame controller: input FSM states,
// frame index type and a constant-foldable ceil(log2) helper.
package fft_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      WAIT = 2'd2
   } in_state_e;

   typedef logic [15:0] frame_idx_t;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/fft_frame_counter.sv
// Modulo-N sample counter with first/last-of-frame flags, used for both the
// input fill position and the output drain position.
module fft_frame_counter
   import fft_ctrl_pkg::*;
#(
   parameter int N = 1024
) (
   input  logic clock,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic first_o,
   output logic last_o
);

   localparam int CW = clog2(N);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign first_o = (cnt_q == '0);
   assign last_o  = (cnt_q == CW'(N - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = last_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame-level flow control around a streaming FFT core: credits input frames
// against MAX_INFLIGHT, tags output frames, flags framing errors.
// Optional watchdog enabled by defining FFT_CTRL_WDOG_EN.
module fft_frame_ctrl
   import fft_ctrl_pkg::*;
#(
   parameter int N            = 1024,
   parameter int WIDTH        = 32,
   parameter int MAX_INFLIGHT = 2,
   parameter int WDOG_CYCLES  = 8192
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data_r,
   input  logic [WIDTH-1:0] s_data_i,
   input  logic             s_last,
   output logic             fft_idata_en,
   output logic [WIDTH-1:0] fft_idata_r,
   output logic [WIDTH-1:0] fft_idata_i,
   input  logic             fft_odata_en,
   input  logic [WIDTH-1:0] fft_odata_r,
   input  logic [WIDTH-1:0] fft_odata_i,
   output logic             m_valid,
   output logic [WIDTH-1:0] m_data_r,
   output logic [WIDTH-1:0] m_data_i,
   output logic             m_sop,
   output logic             m_eop,
   output logic [15:0]      m_frame_idx,
   output logic [2:0]       inflight,
   output logic             err_frame,
   output logic             err_spurious,
   output logic             err_timeout
);

   localparam logic [2:0] MAX_IF = 3'(MAX_INFLIGHT);

   in_state_e        state_q, state_d;
   logic [2:0]       inflight_q, inflight_d;
   logic             accept, in_first, in_last, in_start;
   logic             out_first, out_last, out_eop_evt;
   logic             timeout;

   logic             idata_en_q;
   logic [WIDTH-1:0] idata_r_q, idata_i_q;
   logic             mvalid_q, sop_q, eop_q;
   logic [WIDTH-1:0] mdata_r_q, mdata_i_q;
   frame_idx_t       frame_idx_q;
   logic             err_frame_q, err_spur_q;

   always_comb begin
      s_ready = 1'b0;
      case (state_q)
         IDLE:    s_ready = (inflight_q < MAX_IF);
         FILL:    s_ready = 1'b1;
         default: s_ready = 1'b0;
      endcase
   end

   assign accept      = s_valid && s_ready;
   assign in_start    = accept && in_first;
   assign out_eop_evt = fft_odata_en && out_last;

   fft_frame_counter #(.N(N)) u_in_cnt (
      .clock   (clock),
      .reset   (reset),
      .clr_i   (timeout),
      .en_i    (accept),
      .first_o (in_first),
      .last_o  (in_last)
   );

   fft_frame_counter #(.N(N)) u_out_cnt (
      .clock   (clock),
      .reset   (reset),
      .clr_i   (timeout),
      .en_i    (fft_odata_en),
      .first_o (out_first),
      .last_o  (out_last)
   );

   // A frame start and a frame drain in the same cycle cancel out.
   always_comb begin
      inflight_d = inflight_q;
      if (in_start && !out_eop_evt) begin
         if (inflight_q < MAX_IF) inflight_d = inflight_q + 3'd1;
      end else if (out_eop_evt && !in_start) begin
         if (inflight_q != 3'd0) inflight_d = inflight_q - 3'd1;
      end
      if (timeout) inflight_d = 3'd0;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (inflight_q >= MAX_IF) state_d = WAIT;
            else if (accept)          state_d = FILL;
         end
         FILL: begin
            if (accept && in_last) state_d = (inflight_d < MAX_IF) ? IDLE : WAIT;
         end
         WAIT: begin
            if (inflight_q < MAX_IF) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (timeout) state_d = IDLE;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         inflight_q  <= 3'd0;
         idata_en_q  <= 1'b0;
         idata_r_q   <= '0;
         idata_i_q   <= '0;
         mvalid_q    <= 1'b0;
         mdata_r_q   <= '0;
         mdata_i_q   <= '0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
         frame_idx_q <= '0;
         err_frame_q <= 1'b0;
         err_spur_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         idata_en_q <= accept;
         if (accept) begin
            idata_r_q <= s_data_r;
            idata_i_q <= s_data_i;
         end
         mvalid_q <= fft_odata_en;
         if (fft_odata_en) begin
            mdata_r_q <= fft_odata_r;
            mdata_i_q <= fft_odata_i;
         end
         sop_q <= fft_odata_en && out_first;
         eop_q <= out_eop_evt;
         // Index advances once the eop sample has been presented.
         if (mvalid_q && eop_q) frame_idx_q <= frame_idx_q + 1'b1;
         if (accept && (s_last != in_last)) err_frame_q <= 1'b1;
         if (fft_odata_en && (inflight_q == 3'd0)) err_spur_q <= 1'b1;
      end
   end

`ifdef FFT_CTRL_WDOG_EN
   localparam int WW = clog2(WDOG_CYCLES + 1);

   logic [WW-1:0] wdog_q;
   logic          err_timeout_q;

   assign timeout = (inflight_q != 3'd0) && !fft_odata_en &&
                    (wdog_q == WW'(WDOG_CYCLES - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         wdog_q        <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         if (fft_odata_en || (inflight_q == 3'd0) || timeout) wdog_q <= '0;
         else                                                  wdog_q <= wdog_q + 1'b1;
         if (timeout) err_timeout_q <= 1'b1;
      end
   end

   assign err_timeout = err_timeout_q;
`else
   assign timeout     = 1'b0;
   assign err_timeout = 1'b0;
`endif

   assign fft_idata_en = idata_en_q;
   assign fft_idata_r  = idata_r_q;
   assign fft_idata_i  = idata_i_q;
   assign m_valid      = mvalid_q;
   assign m_data_r     = mdata_r_q;
   assign m_data_i     = mdata_i_q;
   assign m_sop        = sop_q;
   assign m_eop        = eop_q;
   assign m_frame_idx  = frame_idx_q;
   assign inflight     = inflight_q;
   assign err_frame    = err_frame_q;
   assign err_spurious = err_spur_q;

endmodule
